// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Purpose:
//   Shift-and-add unsigned 8x8 multiplier. It uses no adder or shifter of its
//   own. Every arithmetic step is issued to a shared 16-bit ALU that sits
//   outside this block. The ALU result is combinational and comes back on
//   ALU_Out in the same cycle.
//
//   Each multiplier bit takes one pass through TEST -> [ADD] -> SHL -> SHR:
//     - TEST : decide whether this bit contributes a partial product.
//     - ADD  : P  <= P + MC          (FunSel 5'b10100)
//     - SHL  : MC <= MC << 1         (FunSel 5'b11011)
//     - SHR  : MP <= MP >> 1         (FunSel 5'b11100), count++
//   After ITER passes, DONE copies P into Product and pulses Done.
//
// Configuration:
//   ALU_MUL_EARLY_EXIT_EN -- when defined, TEST jumps straight to DONE once
//   the remaining multiplier is zero. The result is unchanged; only the
//   latency gets shorter.
//
// Parameters:
//   ITER        number of multiplier bits processed (1..8)
//
// Ports:
//   Clock       in   1   single clock, rising edge
//   Reset       in   1   synchronous, active-high
//   Start       in   1   multiply request, honoured only in IDLE
//   OpA         in   8   multiplicand (unsigned)
//   OpB         in   8   multiplier   (unsigned)
//   Busy        out  1   high in every state except IDLE
//   Done        out  1   high for the single DONE cycle
//   Product     out  16  result register, held until the next DONE
//   ALU_A       out  16  ALU operand A
//   ALU_B       out  16  ALU operand B
//   ALU_FunSel  out  5   ALU function select
//   ALU_WF      out  1   ALU write/flag enable
//   ALU_Out     in   16  combinational ALU result
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
   parameter int ITER = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  OpA,
   input  logic [7:0]  OpB,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] Product,
   output logic [15:0] ALU_A,
   output logic [15:0] ALU_B,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   input  logic [15:0] ALU_Out
);

   // ALU function codes used by this sequencer
   localparam logic [4:0] FS_NOP = 5'b10000;
   localparam logic [4:0] FS_ADD = 5'b10100;
   localparam logic [4:0] FS_SHL = 5'b11011;
   localparam logic [4:0] FS_SHR = 5'b11100;

   // Iteration target narrowed to the counter width; ITER never exceeds 8
   localparam logic [3:0] ITER_LAST = 4'(ITER);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TEST = 3'd1,
      S_ADD  = 3'd2,
      S_SHL  = 3'd3,
      S_SHR  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t      state_q,   state_d;
   logic [15:0] mc_q,      mc_d;       // multiplicand, shifted left each pass
   logic [15:0] mp_q,      mp_d;       // multiplier, shifted right each pass
   logic [15:0] p_q,       p_d;        // running partial product
   logic [3:0]  count_q,   count_d;    // completed passes
   logic [15:0] product_q, product_d;  // architecturally visible result

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         mc_q      <= 16'h0000;
         mp_q      <= 16'h0000;
         p_q       <= 16'h0000;
         count_q   <= 4'd0;
         product_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         mc_q      <= mc_d;
         mp_q      <= mp_d;
         p_q       <= p_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state, datapath update and ALU command decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      mc_d       = mc_q;
      mp_d       = mp_q;
      p_d        = p_q;
      count_d    = count_q;
      product_d  = product_q;
      ALU_A      = 16'h0000;
      ALU_B      = 16'h0000;
      ALU_FunSel = FS_NOP;
      ALU_WF     = 1'b0;
      Busy       = 1'b1;
      Done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            Busy = 1'b0;
            // Operands are sampled only here, so a change on OpA/OpB or a
            // held Start during the operation has no effect.
            if (Start) begin
               mc_d    = {8'h00, OpA};
               mp_d    = {8'h00, OpB};
               p_d     = 16'h0000;
               count_d = 4'd0;
               state_d = S_TEST;
            end
         end

         S_TEST: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
            // No multiplier bits left means no more partial products, so
            // the remaining passes cannot change P.
            if (mp_q == 16'h0000) begin
               state_d = S_DONE;
            end else if (mp_q[0]) begin
               state_d = S_ADD;
            end else begin
               state_d = S_SHL;
            end
`else
            if (mp_q[0]) begin
               state_d = S_ADD;
            end else begin
               state_d = S_SHL;
            end
`endif
         end

         S_ADD: begin
            ALU_A      = p_q;
            ALU_B      = mc_q;
            ALU_FunSel = FS_ADD;
            ALU_WF     = 1'b1;
            p_d        = ALU_Out;
            state_d    = S_SHL;
         end

         S_SHL: begin
            ALU_A      = mc_q;
            ALU_FunSel = FS_SHL;
            ALU_WF     = 1'b1;
            mc_d       = ALU_Out;
            state_d    = S_SHR;
         end

         S_SHR: begin
            ALU_A      = mp_q;
            ALU_FunSel = FS_SHR;
            ALU_WF     = 1'b1;
            mp_d       = ALU_Out;
            count_d    = count_q + 4'd1;
            if (count_q + 4'd1 == ITER_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_TEST;
            end
         end

         S_DONE: begin
            // Start is deliberately ignored here. A request held across DONE
            // is taken in the following IDLE cycle.
            Done      = 1'b1;
            product_d = p_q;
            state_d   = S_IDLE;
         end

         default: begin
            Busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign Product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

   localparam int ITER = 8;

   // Phase codes for the expected per-cycle sequence
   localparam int C_TEST = 0;
   localparam int C_ADD  = 1;
   localparam int C_SHL  = 2;
   localparam int C_SHR  = 3;
   localparam int C_DONE = 4;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [7:0]  OpA;
   logic [7:0]  OpB;
   logic        Busy;
   logic        Done;
   logic [15:0] Product;
   logic [15:0] ALU_A;
   logic [15:0] ALU_B;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [15:0] ALU_Out;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_seq[$];

   alu_mul_sequencer #(.ITER(ITER)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Start      (Start),
      .OpA        (OpA),
      .OpB        (OpB),
      .Busy       (Busy),
      .Done       (Done),
      .Product    (Product),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_FunSel (ALU_FunSel),
      .ALU_WF     (ALU_WF),
      .ALU_Out    (ALU_Out)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Shared ALU model: only the three functions this sequencer issues
   always_comb begin
      ALU_Out = 16'h0000;
      case (ALU_FunSel)
         5'b10100: ALU_Out = ALU_A + ALU_B;
         5'b11011: ALU_Out = {ALU_A[14:0], 1'b0};
         5'b11100: ALU_Out = {1'b0, ALU_A[15:1]};
         default:  ALU_Out = 16'h0000;
      endcase
   end

   typedef struct {
      logic [7:0]  opa;
      logic [7:0]  opb;
      logic [15:0] prod;
      int          lat_plain;
      int          lat_ee;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected phase per cycle after the accepting edge, derived from OpB
   task automatic build_seq(input logic [7:0] opb);
      logic [7:0] mp;
      mp = opb;
      exp_seq.delete();
      for (int i = 0; i < ITER; i++) begin
         exp_seq.push_back(C_TEST);
`ifdef ALU_MUL_EARLY_EXIT_EN
         if (mp == 8'h00) break;
`endif
         if (mp[0]) exp_seq.push_back(C_ADD);
         exp_seq.push_back(C_SHL);
         exp_seq.push_back(C_SHR);
         mp = mp >> 1;
      end
      exp_seq.push_back(C_DONE);
   endtask

   task automatic check_phase(input int code);
      logic [4:0] fs;
      logic       wf;
      fs = 5'b10000;
      wf = 1'b0;
      case (code)
         C_ADD: begin fs = 5'b10100; wf = 1'b1; end
         C_SHL: begin fs = 5'b11011; wf = 1'b1; end
         C_SHR: begin fs = 5'b11100; wf = 1'b1; end
         default: ;
      endcase
      check("busy_during_op", 32'(Busy), 32'd1);
      check("done_phase", 32'(Done), 32'(code == C_DONE));
      check("alu_wf", 32'(ALU_WF), 32'(wf));
      check("alu_funsel", 32'(ALU_FunSel), 32'(fs));
      if (code != C_ADD) check("alu_b_zero", 32'(ALU_B), 32'd0);
      if (code == C_TEST || code == C_DONE) check("alu_a_zero", 32'(ALU_A), 32'd0);
   endtask

   // Called #1 after an edge with the DUT in IDLE. Returns #1 after the
   // edge that leaves DONE (DUT back in IDLE).
   task automatic run_op(input logic [7:0] opa, input logic [7:0] opb,
                         input logic [15:0] prod, input int lat,
                         input bit hold, input logic [7:0] nxt_a, input logic [7:0] nxt_b);
      int  k;
      bit  seen;
      Start = 1'b1;
      OpA   = opa;
      OpB   = opb;
      @(posedge Clock); #1;
      if (hold) begin
         OpA = nxt_a;
         OpB = nxt_b;
      end else begin
         Start = 1'b0;
      end
      build_seq(opb);
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 200) begin
         if (k < exp_seq.size()) check_phase(exp_seq[k]);
         else check("busy_overrun", 32'(Busy), 32'd0);
         if (Done) begin
            seen = 1'b1;
         end else begin
            @(posedge Clock); #1;
            k++;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(k), 32'(lat));
      @(posedge Clock); #1;
      check("idle_busy", 32'(Busy), 32'd0);
      check("idle_done", 32'(Done), 32'd0);
      check("product", 32'(Product), 32'(prod));
      $display("op %02h * %02h -> product %04h latency %0d", opa, opb, Product, k);
   endtask

   function automatic int pick_lat(input vec_t v);
`ifdef ALU_MUL_EARLY_EXIT_EN
      return v.lat_ee;
`else
      return v.lat_plain;
`endif
   endfunction

   initial begin
      bit   any_done;
      vec_t v;

      //          opa    opb    product    plain  early
      vecs[0] = '{8'h05, 8'h03, 16'h000F, 26,    9};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 32,    32};
      vecs[2] = '{8'h05, 8'h00, 16'h0000, 24,    1};
      vecs[3] = '{8'h00, 8'hFF, 16'h0000, 32,    32};
      vecs[4] = '{8'h0C, 8'h0A, 16'h0078, 26,    15};
      vecs[5] = '{8'h80, 8'h80, 16'h4000, 25,    25};
      vecs[6] = '{8'h01, 8'h01, 16'h0001, 25,    5};
      vecs[7] = '{8'hAA, 8'h55, 16'h3872, 28,    26};

      Reset = 1'b1;
      Start = 1'b0;
      OpA   = 8'h00;
      OpB   = 8'h00;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_product", 32'(Product), 32'd0);
      check("rst_alu_wf", 32'(ALU_WF), 32'd0);
      check("rst_funsel", 32'(ALU_FunSel), 32'(5'b10000));
      @(posedge Clock); #1;

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         run_op(v.opa, v.opb, v.prod, pick_lat(v), 1'b0, 8'h00, 8'h00);
      end

      // Start held through the operation with operands changing mid-way,
      // then accepted again right after DONE with the new operands.
      run_op(8'h05, 8'h03, 16'h000F, pick_lat(vecs[0]), 1'b1, 8'h0C, 8'h0A);
      run_op(8'h0C, 8'h0A, 16'h0078, pick_lat(vecs[4]), 1'b0, 8'h00, 8'h00);

      // Product holds while idle
      repeat (3) @(posedge Clock);
      #1;
      check("product_hold", 32'(Product), 32'h0078);

      // Reset in an ADD cycle of 7 * 9
      Start = 1'b1;
      OpA   = 8'h07;
      OpB   = 8'h09;
      @(posedge Clock); #1;
      Start = 1'b0;
      check("abort_test_wf", 32'(ALU_WF), 32'd0);
      @(posedge Clock); #1;
      check("abort_add_wf", 32'(ALU_WF), 32'd1);
      check("abort_add_fs", 32'(ALU_FunSel), 32'(5'b10100));
      check("abort_add_a", 32'(ALU_A), 32'd0);
      check("abort_add_b", 32'(ALU_B), 32'd7);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_product", 32'(Product), 32'd0);
      any_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (Done || Busy) any_done = 1'b1;
         @(posedge Clock); #1;
      end
      check("abort_no_done", 32'(any_done), 32'd0);
      $display("abort 07 * 09 in ADD -> busy %0b product %04h", Busy, Product);

      // Fresh operation after the abort
      v = '{8'h07, 8'h09, 16'h003F, 26, 15};
      run_op(v.opa, v.opb, v.prod, pick_lat(v), 1'b0, 8'h00, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
